// File: rtl/reg_file_p_pkg.sv
// reg_file_p_pkg -- shared types and default sizes for the reg_file_p slice.
//   state_t      : clear-sequencer FSM state (IDLE, CLEAR)
//   DATA_W_DEF   : default entry width in bits
//   ADDR_W_DEF   : default address width (DEPTH = 2**ADDR_W)
//   NUM_RD_DEF   : default number of asynchronous read ports
package reg_file_p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int NUM_RD_DEF = 2;

endpackage

// File: rtl/reg_file_p_clr_seq.sv
// reg_file_p_clr_seq -- clear sequencer for reg_file_p.
// Sweeps a pointer across every entry, one entry per cycle, while busy is
// high. Entered on clr from IDLE or on rst from any state.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (forces a fresh sweep)
//   clr      : request a full clear (ignored while a sweep is running)
//   busy     : high in every sweep cycle
//   clr_done : one-cycle pulse in the final sweep cycle
//   ptr      : entry to zero this cycle (held at 0 in IDLE)
module reg_file_p_clr_seq
  import reg_file_p_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST_PTR   = '1;
  localparam logic [ADDR_W-1:0] PENULT_PTR = LAST_PTR - ADDR_W'(1);

  state_t state;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking here would make ordering within the block matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      ptr      <= '0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ptr      <= '0;
          clr_done <= 1'b0;
          if (clr) state <= CLEAR;
        end
        CLEAR: begin
          // clr is deliberately not looked at here: no restart, no extension.
          if (ptr == LAST_PTR) begin
            state    <= IDLE;
            ptr      <= '0;
            clr_done <= 1'b0;
          end else begin
            ptr      <= ptr + ADDR_W'(1);
            // Raised one edge early so the pulse lines up with the last
            // sweep cycle while still coming straight from a flop.
            clr_done <= (ptr == PENULT_PTR);
          end
        end
        default: begin
          state    <= CLEAR;
          ptr      <= '0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == CLEAR);

endmodule

// File: rtl/reg_file_p.sv
// reg_file_p -- parameterised register file with NUM_RD asynchronous read
// ports, one write port and a sequenced whole-array clear.
// Build option: define REG_FILE_P_BYPASS_EN for write-through reads (a read
// port addressing the entry being written sees wdata in the same cycle).
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset; starts a clear sweep
//   clr      : request to zero the whole array
//   we       : write enable
//   waddr    : write address
//   wdata    : write data
//   w_ready  : write presented this cycle is accepted
//   raddr    : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata    : packed read data, port i at [i*DATA_W +: DATA_W]
//   busy     : clear sweep in progress (all reads return 0)
//   clr_done : one-cycle pulse in the final sweep cycle
module reg_file_p
  import reg_file_p_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  output logic                     w_ready,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     busy,
  output logic                     clr_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_ptr;
  logic              wr_fire;

  reg_file_p_clr_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_done (clr_done),
    .ptr      (clr_ptr)
  );

  // busy is decoded from the CLEAR state, so this is (state==IDLE) && !clr.
  assign w_ready = !busy && !clr;
  // rst outranks a write even when the sequencer happens to be idle.
  assign wr_fire = we && w_ready && !rst;

  // NOTE: the array has no reset branch; it is zeroed by the sweep that
  // rst starts, which keeps it mappable onto plain RAM/flops without resets.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy)         mem[clr_ptr] <= '0;
      else if (wr_fire) mem[waddr]   <= wdata;
    end
  end

  // NOTE: rdata gets a full default before the loop so no path through the
  // block leaves it unassigned, which would otherwise infer latches.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!busy) begin
`ifdef REG_FILE_P_BYPASS_EN
        if (wr_fire && (raddr[i*ADDR_W +: ADDR_W] == waddr))
          rdata[i*DATA_W +: DATA_W] = wdata;
        else
          rdata[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
`else
        rdata[i*DATA_W +: DATA_W] = mem[raddr[i*ADDR_W +: ADDR_W]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_p.sv
// tb_reg_file_p -- directed, table-driven bench for reg_file_p.
// Instance u_dut uses the default sizes (8-bit, 16 entries, 2 ports);
// u_dut_b uses DATA_W=16, ADDR_W=3, NUM_RD=4.
module tb_reg_file_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-size instance.
  logic        rst, clr, we, w_ready, busy, clr_done;
  logic [3:0]  waddr;
  logic [7:0]  wdata;
  logic [7:0]  raddr;
  logic [15:0] rdata;

  // Parameter-sweep instance.
  logic        rst_b, clr_b, we_b, w_ready_b, busy_b, clr_done_b;
  logic [2:0]  waddr_b;
  logic [15:0] wdata_b;
  logic [11:0] raddr_b;
  logic [63:0] rdata_b;

  reg_file_p u_dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .w_ready  (w_ready),
    .raddr    (raddr),
    .rdata    (rdata),
    .busy     (busy),
    .clr_done (clr_done)
  );

  reg_file_p #(
    .DATA_W (16),
    .ADDR_W (3),
    .NUM_RD (4)
  ) u_dut_b (
    .clk      (clk),
    .rst      (rst_b),
    .clr      (clr_b),
    .we       (we_b),
    .waddr    (waddr_b),
    .wdata    (wdata_b),
    .w_ready  (w_ready_b),
    .raddr    (raddr_b),
    .rdata    (rdata_b),
    .busy     (busy_b),
    .clr_done (clr_done_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic [3:0] ra0;
    logic [3:0] ra1;
    logic [7:0] exp0;
    logic [7:0] exp1;
  } vec_t;

  vec_t vecs [9];

  logic [15:0] exp_b [8];

  initial begin
    // Reads never address the entry being written in the same vector, so
    // expectations hold with or without write-through.
    vecs[0] = '{1'b1, 4'd3,  8'hA5, 4'd0,  4'd1,  8'h00, 8'h00};
    vecs[1] = '{1'b1, 4'd12, 8'h5A, 4'd3,  4'd3,  8'hA5, 8'hA5};
    vecs[2] = '{1'b0, 4'd0,  8'h00, 4'd3,  4'd12, 8'hA5, 8'h5A};
    vecs[3] = '{1'b1, 4'd15, 8'hFF, 4'd12, 4'd0,  8'h5A, 8'h00};
    vecs[4] = '{1'b0, 4'd0,  8'h00, 4'd15, 4'd3,  8'hFF, 8'hA5};
    vecs[5] = '{1'b1, 4'd3,  8'h11, 4'd15, 4'd15, 8'hFF, 8'hFF};
    vecs[6] = '{1'b0, 4'd0,  8'h00, 4'd3,  4'd0,  8'h11, 8'h00};
    vecs[7] = '{1'b1, 4'd0,  8'h80, 4'd12, 4'd3,  8'h5A, 8'h11};
    vecs[8] = '{1'b0, 4'd0,  8'h00, 4'd0,  4'd15, 8'h80, 8'hFF};

    rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    rst_b = 1'b1; clr_b = 1'b0; we_b = 1'b0; waddr_b = '0; wdata_b = '0; raddr_b = '0;

    // ---- Reset followed by the power-on sweep ----
    step();
    rst = 1'b0;
    raddr = {4'd15, 4'd4};
    for (int c = 1; c <= 16; c++) begin
      #1;
      check($sformatf("rst_busy_c%0d", c), busy, 1'b1);
      check($sformatf("rst_done_c%0d", c), clr_done, (c == 16));
      check($sformatf("rst_wready_c%0d", c), w_ready, 1'b0);
      check($sformatf("rst_rdata_c%0d", c), rdata, 16'h0000);
      step();
    end
    #1;
    check("rst_busy_after", busy, 1'b0);
    check("rst_done_after", clr_done, 1'b0);
    check("rst_wready_after", w_ready, 1'b1);
    for (int a = 0; a < 16; a++) begin
      raddr = {4'(15 - a), 4'(a)};
      #1;
      check($sformatf("rst_zero_a%0d", a), rdata, 16'h0000);
    end
    step();

    // ---- Table-driven writes and two-port reads ----
    for (int v = 0; v < 9; v++) begin
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      raddr = {vecs[v].ra1, vecs[v].ra0};
      #1;
      check($sformatf("vec%0d_rd0", v), rdata[7:0],  vecs[v].exp0);
      check($sformatf("vec%0d_rd1", v), rdata[15:8], vecs[v].exp1);
      check($sformatf("vec%0d_wready", v), w_ready, 1'b1);
      step();
    end
    we = 1'b0;

    // ---- clr with a simultaneous write, then clr re-pulsed mid-sweep ----
    clr = 1'b1; we = 1'b1; waddr = 4'd7; wdata = 8'hFF;
    #1;
    check("clrwr_wready", w_ready, 1'b0);
    check("clrwr_busy_pre", busy, 1'b0);
    step();
    clr = 1'b0; we = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      clr = (c == 5) || (c == 16);
      #1;
      check($sformatf("clr_busy_c%0d", c), busy, 1'b1);
      check($sformatf("clr_done_c%0d", c), clr_done, (c == 16));
      step();
    end
    clr = 1'b0;
    raddr = {4'd3, 4'd7};
    #1;
    check("clr_busy_after", busy, 1'b0);
    check("clr_addr7", rdata[7:0], 8'h00);
    check("clr_addr3", rdata[15:8], 8'h00);
    step();

    // ---- rst in sweep cycle 9: restart, writes during sweep dropped ----
    we = 1'b1; waddr = 4'd9; wdata = 8'h77;
    step();
    we = 1'b0; raddr = {4'd9, 4'd9};
    #1;
    check("pre_rst_addr9", rdata, 16'h7777);
    clr = 1'b1;
    step();
    clr = 1'b0;
    we = 1'b1; waddr = 4'd2; wdata = 8'hEE;
    for (int c = 1; c <= 9; c++) begin
      rst = (c == 9);
      #1;
      check($sformatf("mid_busy_c%0d", c), busy, 1'b1);
      check($sformatf("mid_done_c%0d", c), clr_done, 1'b0);
      check($sformatf("mid_wready_c%0d", c), w_ready, 1'b0);
      step();
    end
    rst = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      #1;
      check($sformatf("rs_busy_c%0d", c), busy, 1'b1);
      check($sformatf("rs_done_c%0d", c), clr_done, (c == 16));
      step();
    end
    we = 1'b0;
    raddr = {4'd9, 4'd2};
    #1;
    check("rs_busy_after", busy, 1'b0);
    check("rs_addr2_dropped", rdata[7:0], 8'h00);
    check("rs_addr9_cleared", rdata[15:8], 8'h00);
    step();

    // ---- Same-cycle read of the entry being written ----
    we = 1'b1; waddr = 4'd5; wdata = 8'h3C; raddr = {4'd6, 4'd5};
    #1;
`ifdef REG_FILE_P_BYPASS_EN
    check("byp_same_cycle", rdata[7:0], 8'h3C);
`else
    check("byp_same_cycle", rdata[7:0], 8'h00);
`endif
    check("byp_other_port", rdata[15:8], 8'h00);
    step();
    we = 1'b0;
    #1;
    check("byp_next_cycle", rdata[7:0], 8'h3C);
    step();

    // ---- Parameter sweep instance: 8-entry clear, four 16-bit ports ----
    rst_b = 1'b0;
    raddr_b = {3'd7, 3'd6, 3'd1, 3'd0};
    for (int c = 1; c <= 8; c++) begin
      #1;
      check($sformatf("b_busy_c%0d", c), busy_b, 1'b1);
      check($sformatf("b_done_c%0d", c), clr_done_b, (c == 8));
      check($sformatf("b_rdata_c%0d", c), rdata_b[31:0], 32'h0);
      step();
    end
    #1;
    check("b_busy_after", busy_b, 1'b0);
    check("b_wready_after", w_ready_b, 1'b1);
    exp_b[0] = 16'h8001; exp_b[1] = 16'h1234; exp_b[6] = 16'hBEEF; exp_b[7] = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      we_b = 1'b1;
      waddr_b = (k == 0) ? 3'd1 : (k == 1) ? 3'd6 : (k == 2) ? 3'd7 : 3'd0;
      wdata_b = exp_b[waddr_b];
      step();
    end
    we_b = 1'b0;
    raddr_b = {3'd0, 3'd7, 3'd6, 3'd1};
    #1;
    check("b_port0", rdata_b[15:0],  16'h1234);
    check("b_port1", rdata_b[31:16], 16'hBEEF);
    check("b_port2", rdata_b[47:32], 16'hFFFF);
    check("b_port3", rdata_b[63:48], 16'h8001);
    raddr_b = {3'd6, 3'd6, 3'd6, 3'd6};
    #1;
    for (int p = 0; p < 4; p++)
      check($sformatf("b_same_p%0d", p), rdata_b[p*16 +: 16], 16'hBEEF);
    raddr_b = {3'd5, 3'd4, 3'd3, 3'd2};
    #1;
    check("b_untouched", rdata_b, 64'h0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
